// File: rtl/maze_pkg.sv
// Shared types for the maze design: ROM geometry, arbiter states and
// the tags that route ROM read data back to its requester.
package maze_pkg;

    localparam int ROM_ADDR_W = 11;
    localparam int ROM_DATA_W = 16;

    typedef enum logic [0:0] {
        ARB_VID_PRI,
        ARB_CTL_FORCE
    } arb_state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VID,
        TAG_CTL
    } rom_tag_t;

endpackage

// File: rtl/rom_tag_pipe.sv
// Shift register of requester tags, aligned with the ROM read latency
// so each returning word can be steered to the port that asked for it.
module rom_tag_pipe
    import maze_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  rom_tag_t i_tag,
    output rom_tag_t o_tag
);

    rom_tag_t tag_q [DEPTH];
    rom_tag_t tag_d [DEPTH];

    always_comb begin
        tag_d[0] = i_tag;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    assign o_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/maze_rom_arbiter.sv
// Shares the maze ROM between the video renderer (priority) and the game
// controller, with a starvation guard that forces a controller access.
module maze_rom_arbiter
    import maze_pkg::*;
#(
    parameter int ADDR_W       = ROM_ADDR_W,
    parameter int DATA_W       = ROM_DATA_W,
    parameter int ROM_LAT      = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic              o_vid_gnt,
    output logic              o_vid_rvalid,
    output logic [DATA_W-1:0] o_vid_rdata,
    input  logic              i_ctl_req,
    input  logic [ADDR_W-1:0] i_ctl_addr,
    output logic              o_ctl_gnt,
    output logic              o_ctl_rvalid,
    output logic [DATA_W-1:0] o_ctl_rdata,
    output logic              o_rom_en,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic [7:0]        o_starve_cnt
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT - 1);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]        starve_q, starve_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              vid_rvalid_q, vid_rvalid_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic              ctl_rvalid_q, ctl_rvalid_d;
    logic [DATA_W-1:0] ctl_rdata_q, ctl_rdata_d;
    logic              vid_gnt, ctl_gnt;
    rom_tag_t          gnt_tag, ret_tag;

    always_comb begin
        vid_gnt  = 1'b0;
        ctl_gnt  = 1'b0;
        state_d  = state_q;
        wait_d   = wait_q;
        starve_d = starve_q;
        if (!rst) begin
            unique case (state_q)
                ARB_VID_PRI: begin
                    vid_gnt = i_vid_req;
                    ctl_gnt = i_ctl_req && !i_vid_req;
                    if (i_ctl_req && !ctl_gnt) begin
                        if (wait_q == WAIT_MAX) begin
                            state_d = ARB_CTL_FORCE;
                            wait_d  = '0;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end else begin
                        wait_d = '0;
                    end
                end
                ARB_CTL_FORCE: begin
                    // A dropped ctl request here is a protocol slip: no grant.
                    ctl_gnt = i_ctl_req;
                    if (i_ctl_req && starve_q != 8'hFF) begin
                        starve_d = starve_q + 8'd1;
                    end
                    state_d = ARB_VID_PRI;
                    wait_d  = '0;
                end
                default: state_d = ARB_VID_PRI;
            endcase
        end
    end

    always_comb begin
        gnt_tag = TAG_NONE;
        if (vid_gnt) begin
            gnt_tag = TAG_VID;
        end else if (ctl_gnt) begin
            gnt_tag = TAG_CTL;
        end
        rom_en_d   = vid_gnt || ctl_gnt;
        rom_addr_d = rom_addr_q;
        if (vid_gnt) begin
            rom_addr_d = i_vid_addr;
        end else if (ctl_gnt) begin
            rom_addr_d = i_ctl_addr;
        end
        vid_rvalid_d = (ret_tag == TAG_VID);
        ctl_rvalid_d = (ret_tag == TAG_CTL);
        vid_rdata_d  = vid_rvalid_d ? i_rom_data : vid_rdata_q;
        ctl_rdata_d  = ctl_rvalid_d ? i_rom_data : ctl_rdata_q;
    end

    rom_tag_pipe #(
        .DEPTH (1 + ROM_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (gnt_tag),
        .o_tag (ret_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_VID_PRI;
            wait_q       <= '0;
            starve_q     <= '0;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            vid_rvalid_q <= 1'b0;
            vid_rdata_q  <= '0;
            ctl_rvalid_q <= 1'b0;
            ctl_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            starve_q     <= starve_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            vid_rvalid_q <= vid_rvalid_d;
            vid_rdata_q  <= vid_rdata_d;
            ctl_rvalid_q <= ctl_rvalid_d;
            ctl_rdata_q  <= ctl_rdata_d;
        end
    end

    assign o_vid_gnt    = vid_gnt;
    assign o_ctl_gnt    = ctl_gnt;
    assign o_rom_en     = rom_en_q;
    assign o_rom_addr   = rom_addr_q;
    assign o_vid_rvalid = vid_rvalid_q;
    assign o_vid_rdata  = vid_rdata_q;
    assign o_ctl_rvalid = ctl_rvalid_q;
    assign o_ctl_rdata  = ctl_rdata_q;
    assign o_starve_cnt = starve_q;

endmodule

// File: tb/tb_maze_rom_arbiter.sv
// Randomized and directed bench for maze_rom_arbiter against a
// cycle-stamped transaction model of the arbitration rules.
module tb_maze_rom_arbiter;
    import maze_pkg::*;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vid_req, i_ctl_req;
    logic [10:0] i_vid_addr, i_ctl_addr;
    logic        o_vid_gnt, o_ctl_gnt;
    logic        o_vid_rvalid, o_ctl_rvalid;
    logic [15:0] o_vid_rdata, o_ctl_rdata;
    logic        o_rom_en;
    logic [10:0] o_rom_addr;
    logic [15:0] i_rom_data = '0;
    logic [7:0]  o_starve_cnt;

    always #5 clk = ~clk;

    maze_rom_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_vid_req    (i_vid_req),
        .i_vid_addr   (i_vid_addr),
        .o_vid_gnt    (o_vid_gnt),
        .o_vid_rvalid (o_vid_rvalid),
        .o_vid_rdata  (o_vid_rdata),
        .i_ctl_req    (i_ctl_req),
        .i_ctl_addr   (i_ctl_addr),
        .o_ctl_gnt    (o_ctl_gnt),
        .o_ctl_rvalid (o_ctl_rvalid),
        .o_ctl_rdata  (o_ctl_rdata),
        .o_rom_en     (o_rom_en),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (i_rom_data),
        .o_starve_cnt (o_starve_cnt)
    );

    function automatic logic [15:0] rom_f(logic [10:0] a);
        return {5'b0, a} ^ 16'hA5A5;
    endfunction

    // one-cycle-latency ROM
    always @(posedge clk) begin
        if (o_rom_en) i_rom_data <= rom_f(o_rom_addr);
    end

    int          checks = 0;
    int          failures = 0;
    int          cyc;
    logic [10:0] en_at [int];
    logic [15:0] vret [int];
    logic [15:0] cret [int];
    logic [10:0] m_addr;
    logic [15:0] m_vdata, m_cdata;
    int          m_starve, m_wait;
    bit          m_force;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic m_reset();
        en_at.delete();
        vret.delete();
        cret.delete();
        m_addr   = '0;
        m_vdata  = '0;
        m_cdata  = '0;
        m_starve = 0;
        m_wait   = 0;
        m_force  = 1'b0;
    endtask

    task automatic step(input bit vr, input logic [10:0] va,
                        input bit cr, input logic [10:0] ca,
                        input bit r, output bit gv, output bit gc);
        i_vid_req  = vr;
        i_vid_addr = va;
        i_ctl_req  = cr;
        i_ctl_addr = ca;
        rst        = r;
        gv = 1'b0;
        gc = 1'b0;
        if (!r) begin
            if (m_force) begin
                gc = cr;
            end else begin
                gv = vr;
                gc = cr && !vr;
            end
        end
        @(negedge clk);
        chk("vid_gnt", o_vid_gnt, gv);
        chk("ctl_gnt", o_ctl_gnt, gc);
        if (en_at.exists(cyc)) m_addr = en_at[cyc];
        chk("rom_en", o_rom_en, en_at.exists(cyc));
        chk("rom_addr", o_rom_addr, m_addr);
        if (vret.exists(cyc)) m_vdata = vret[cyc];
        chk("vid_rvalid", o_vid_rvalid, vret.exists(cyc));
        chk("vid_rdata", o_vid_rdata, m_vdata);
        if (cret.exists(cyc)) m_cdata = cret[cyc];
        chk("ctl_rvalid", o_ctl_rvalid, cret.exists(cyc));
        chk("ctl_rdata", o_ctl_rdata, m_cdata);
        chk("starve_cnt", o_starve_cnt, m_starve);
        if (r) begin
            m_reset();
        end else begin
            if (gv) begin
                en_at[cyc+1] = va;
                vret[cyc+3]  = rom_f(va);
            end
            if (gc) begin
                en_at[cyc+1] = ca;
                cret[cyc+3]  = rom_f(ca);
            end
            if (m_force) begin
                if (gc && m_starve < 255) m_starve++;
                m_force = 1'b0;
                m_wait  = 0;
            end else if (cr && !gc) begin
                if (m_wait == LIMIT - 1) begin
                    m_force = 1'b1;
                    m_wait  = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n);
        bit gv, gc;
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, gv, gc);
    endtask

    initial begin
        bit          gv, gc;
        bit          vr, cr, r;
        logic [10:0] va, ca;

        rst = 1'b1;
        i_vid_req = 1'b0;
        i_ctl_req = 1'b0;
        i_vid_addr = '0;
        i_ctl_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        m_reset();
        cyc = 0;

        // ctl-only read
        step(0, '0, 1, 11'h2A5, 0, gv, gc);
        idle(4);
        chk("t1_rdata", o_ctl_rdata, rom_f(11'h2A5));
        chk("t1_vid_rdata", o_vid_rdata, 16'h0);

        // both requesting: starvation guard
        for (int i = 0; i < 10; i++)
            step(1, 11'(16 * i + 1), i <= LIMIT, 11'h155, 0, gv, gc);
        idle(4);
        chk("t2_starve", o_starve_cnt, 8'd1);
        chk("t2_ctl_rdata", o_ctl_rdata, rom_f(11'h155));

        // alternating grants
        step(1, 11'h010, 0, '0, 0, gv, gc);
        step(0, '0, 1, 11'h020, 0, gv, gc);
        step(1, 11'h030, 0, '0, 0, gv, gc);
        idle(4);
        chk("t3_vid_rdata", o_vid_rdata, rom_f(11'h030));
        chk("t3_ctl_rdata", o_ctl_rdata, rom_f(11'h020));

        // reset right after a vid grant
        step(1, 11'h077, 0, '0, 0, gv, gc);
        step(0, '0, 0, '0, 1, gv, gc);
        idle(4);
        chk("t4_vid_rdata", o_vid_rdata, 16'h0);

        // ctl drops in the forced cycle
        for (int i = 0; i < LIMIT; i++)
            step(1, 11'(i + 3), 1, 11'h3C3, 0, gv, gc);
        step(1, 11'h0AA, 0, '0, 0, gv, gc);
        chk("t6_no_gnt", {31'b0, gv | gc}, 32'd0);
        step(1, 11'h0AA, 0, '0, 0, gv, gc);
        idle(4);
        chk("t6_starve", o_starve_cnt, 8'd0);

        // saturation after 300 forced grants
        for (int i = 0; i < 300 * (LIMIT + 1); i++)
            step(1, 11'($urandom), 1, 11'h0F0, 0, gv, gc);
        idle(4);
        chk("t5_sat", o_starve_cnt, 8'd255);

        // random traffic with occasional resets
        step(0, '0, 0, '0, 1, gv, gc);
        vr = 0; cr = 0; va = '0; ca = '0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            step(vr, va, cr, ca, r, gv, gc);
            if (!vr || gv || r) begin
                vr = ($urandom_range(0, 2) != 0);
                va = 11'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                vr = 0;
            end
            if (!cr || gc || r) begin
                cr = ($urandom_range(0, 1) != 0);
                ca = 11'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                cr = 0;
            end
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
